// File: rtl/pipe_pkg.sv
// pipe_pkg: shared writeback-side encodings and the writeback entry type.
//   SRC_*  : m_src result-source select codes (3 is reserved and behaves as ALU)
//   LD_*   : m_ld load-width codes (unlisted codes behave as LW)
//   wb_entry_t : one formatted GRF write candidate (valid, wen, dst, data, pc)
package pipe_pkg;
  localparam logic [1:0] SRC_ALU  = 2'd0;
  localparam logic [1:0] SRC_MEM  = 2'd1;
  localparam logic [1:0] SRC_LINK = 2'd2;

  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LH  = 3'd1;
  localparam logic [2:0] LD_LHU = 3'd2;
  localparam logic [2:0] LD_LB  = 3'd3;
  localparam logic [2:0] LD_LBU = 3'd4;

  typedef struct packed {
    logic        valid;
    logic        wen;
    logic [4:0]  dst;
    logic [31:0] data;
    logic [31:0] pc;
  } wb_entry_t;
endpackage

// File: rtl/wb_writer_load_ext.sv
// load_ext: combinational load-data extraction and extension.
//   mem    in  32  raw aligned data-memory word
//   addrLo in  2   low byte-address bits (bit 0 ignored for halfwords)
//   ld     in  3   load kind (LD_* codes; others treated as LW)
//   data   out 32  extended load result
module load_ext
  import pipe_pkg::*;
(
  input  logic [31:0] mem,
  input  logic [1:0]  addrLo,
  input  logic [2:0]  ld,
  output logic [31:0] data
);
  logic [15:0] half;
  logic [7:0]  byteSel;

  assign half = addrLo[1] ? mem[31:16] : mem[15:0];

  always_comb begin
    case (addrLo)
      2'd0:    byteSel = mem[7:0];
      2'd1:    byteSel = mem[15:8];
      2'd2:    byteSel = mem[23:16];
      default: byteSel = mem[31:24];
    endcase
  end

  always_comb begin
    case (ld)
      LD_LH:   data = {{16{half[15]}}, half};
      LD_LHU:  data = {16'h0, half};
      LD_LB:   data = {{24{byteSel[7]}}, byteSel};
      LD_LBU:  data = {24'h0, byteSel};
      default: data = mem;
    endcase
  end
endmodule

// File: rtl/wb_writer.sv
// wb_writer: writeback producer for the GRF write port.
// Formats M-stage results (ALU / load-extended MEM / LINK pc+8), arbitrates
// them against mult/div completions, and drives a registered write port.
// A one-entry skid buffer holds an M entry that lost to an md result, so
// neither source is ever dropped and M order is preserved.
// Ports:
//   clk, reset (sync, active-high)
//   m_*  : M-stage offer (valid/ready handshake) with pc, wen, dst, src, alu, mem, addr_lo, ld
//   md_* : mult/div completion offer; md_ready pulses when it is taken
//   reg_write/write_reg/result/pc_w/retire : registered GRF port
//   pending : per-register mask of writes still held in the skid buffer
// Optional: define TRACE_DISPLAY_EN to print one line per GRF write.
module wb_writer
  import pipe_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  output logic        m_ready,
  input  logic [31:0] m_pc,
  input  logic        m_wen,
  input  logic [4:0]  m_dst,
  input  logic [1:0]  m_src,
  input  logic [31:0] m_alu,
  input  logic [31:0] m_mem,
  input  logic [1:0]  m_addr_lo,
  input  logic [2:0]  m_ld,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [31:0] md_pc,
  input  logic [4:0]  md_dst,
  input  logic [31:0] md_data,
  output logic        reg_write,
  output logic [4:0]  write_reg,
  output logic [31:0] result,
  output logic [31:0] pc_w,
  output logic        retire,
  output logic [31:0] pending
);
  wb_entry_t   sk, mEnt, win;
  logic [31:0] ldData;
  logic        mAcc;

  load_ext uLoadExt (
    .mem    (m_mem),
    .addrLo (m_addr_lo),
    .ld     (m_ld),
    .data   (ldData)
  );

  assign m_ready  = !sk.valid;
  assign md_ready = md_valid && !sk.valid;
  assign mAcc     = m_valid && m_ready;

  always_comb begin
    mEnt.valid = mAcc;
    mEnt.wen   = m_wen;
    mEnt.dst   = m_dst;
    mEnt.pc    = m_pc;
    case (m_src)
      SRC_MEM:  mEnt.data = ldData;
      SRC_LINK: mEnt.data = m_pc + 32'd8;
      default:  mEnt.data = m_alu;
    endcase
  end

  // Skid first (it is older than anything offered now), then md, then M.
  always_comb begin
    win = '0;
    if (sk.valid)     win = sk;
    else if (md_valid) win = '{valid: 1'b1, wen: 1'b1, dst: md_dst, data: md_data, pc: md_pc};
    else if (mAcc)    win = mEnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sk        <= '0;
      reg_write <= 1'b0;
      write_reg <= '0;
      result    <= '0;
      pc_w      <= PC_RESET;
      retire    <= 1'b0;
    end else begin
      // A full skid always wins, and M is stalled while it is full, so the
      // only way to fill it is md and M arriving together with it empty.
      if (sk.valid)                sk <= '0;
      else if (md_valid && mAcc)   sk <= mEnt;

      retire    <= win.valid;
      reg_write <= win.valid && win.wen && (win.dst != 5'd0);
      if (win.valid) begin
        write_reg <= win.dst;
        result    <= win.data;
        pc_w      <= win.pc;
      end
`ifdef TRACE_DISPLAY_EN
      if (win.valid && win.wen && (win.dst != 5'd0))
        $display("%d@%h: $%d <= %h", $time, win.pc, win.dst, win.data);
`endif
    end
  end

  // The GRF forwards its own write-port data, so only the skid is reported.
  always_comb begin
    pending = '0;
    if (sk.valid && sk.wen) pending[sk.dst] = 1'b1;
    pending[0] = 1'b0;
  end
endmodule

// File: tb/tb_wb_writer.sv
module tb_wb_writer;
  logic        clk = 1'b0;
  logic        reset;
  logic        m_valid, m_ready, m_wen;
  logic [31:0] m_pc, m_alu, m_mem;
  logic [4:0]  m_dst;
  logic [1:0]  m_src, m_addr_lo;
  logic [2:0]  m_ld;
  logic        md_valid, md_ready;
  logic [31:0] md_pc, md_data;
  logic [4:0]  md_dst;
  logic        reg_write, retire;
  logic [4:0]  write_reg;
  logic [31:0] result, pc_w, pending;

  typedef struct packed {
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] res;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  wb_writer #(.PC_RESET(32'h0000_3000)) dut (
    .clk(clk), .reset(reset),
    .m_valid(m_valid), .m_ready(m_ready), .m_pc(m_pc), .m_wen(m_wen),
    .m_dst(m_dst), .m_src(m_src), .m_alu(m_alu), .m_mem(m_mem),
    .m_addr_lo(m_addr_lo), .m_ld(m_ld),
    .md_valid(md_valid), .md_ready(md_ready), .md_pc(md_pc),
    .md_dst(md_dst), .md_data(md_data),
    .reg_write(reg_write), .write_reg(write_reg), .result(result),
    .pc_w(pc_w), .retire(retire), .pending(pending)
  );

  always #5 clk = ~clk;

  // Monitor: every retire pops the oldest expected write.
  always @(negedge clk) begin
    if (retire) begin
      exp_t e;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_retire: got rw=%0b reg=%0d data=%h pc=%h, required none",
                 reg_write, write_reg, result, pc_w);
      end else begin
        e = q.pop_front();
        if (reg_write !== e.rw || write_reg !== e.wr || result !== e.res || pc_w !== e.pc) begin
          bad++;
          $display("FAIL retire_port: got rw=%0b reg=%0d data=%h pc=%h, required rw=%0b reg=%0d data=%h pc=%h",
                   reg_write, write_reg, result, pc_w, e.rw, e.wr, e.res, e.pc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m_valid = 0; m_wen = 0; m_dst = 0; m_src = 0; m_alu = 0; m_mem = 0;
    m_addr_lo = 0; m_ld = 0; m_pc = 0;
    md_valid = 0; md_dst = 0; md_data = 0; md_pc = 0;
  endtask

  task automatic mSet(input logic [31:0] pc, input logic wen, input logic [4:0] dst,
                      input logic [1:0] src, input logic [31:0] alu, input logic [31:0] mem,
                      input logic [1:0] lo, input logic [2:0] ld);
    m_valid = 1; m_pc = pc; m_wen = wen; m_dst = dst; m_src = src;
    m_alu = alu; m_mem = mem; m_addr_lo = lo; m_ld = ld;
  endtask

  task automatic mdSet(input logic [31:0] pc, input logic [4:0] dst, input logic [31:0] data);
    md_valid = 1; md_pc = pc; md_dst = dst; md_data = data;
  endtask

  task automatic resetChecks(input string tag);
    chk({tag, "_reg_write"}, {31'h0, reg_write}, 32'h0);
    chk({tag, "_write_reg"}, {27'h0, write_reg}, 32'h0);
    chk({tag, "_result"},    result, 32'h0);
    chk({tag, "_pc_w"},      pc_w, 32'h0000_3000);
    chk({tag, "_retire"},    {31'h0, retire}, 32'h0);
    chk({tag, "_pending"},   pending, 32'h0);
    chk({tag, "_m_ready"},   {31'h0, m_ready}, 32'h1);
    chk({tag, "_md_ready"},  {31'h0, md_ready}, 32'h0);
  endtask

  // Load table: ld, addr_lo, expected data (mem = 80FF_7F01).
  logic [2:0]  ldT [10] = '{3'd3, 3'd3, 3'd4, 3'd1, 3'd2, 3'd0, 3'd1, 3'd7, 3'd4, 3'd3};
  logic [1:0]  loT [10] = '{2'd0, 2'd3, 2'd3, 2'd2, 2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd2};
  logic [31:0] exT [10] = '{32'h0000_0001, 32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                            32'h0000_7F01, 32'h80FF_7F01, 32'hFFFF_80FF, 32'h80FF_7F01,
                            32'h0000_007F, 32'hFFFF_FFFF};

  initial begin
    idle();
    reset = 1;
    step(); step();
    resetChecks("reset");
    reset = 0;

    // ALU then LINK.
    mSet(32'h3000, 1, 5'd5, 2'd0, 32'h1234, 32'h0, 2'd0, 3'd0);
    q.push_back('{1'b1, 5'd5, 32'h1234, 32'h3000});
    step();
    mSet(32'h3004, 1, 5'd31, 2'd2, 32'hDEAD_BEEF, 32'h0, 2'd0, 3'd0);
    q.push_back('{1'b1, 5'd31, 32'h300C, 32'h3004});
    step();
    idle();
    step();
    chk("idle_retire", {31'h0, retire}, 32'h0);
    chk("idle_pc_hold", pc_w, 32'h3004);

    // Loads.
    for (int i = 0; i < 10; i++) begin
      mSet(32'h3010 + 32'(i * 4), 1, 5'(i + 1), 2'd1, 32'h0, 32'h80FF_7F01, loT[i], ldT[i]);
      q.push_back('{1'b1, 5'(i + 1), exT[i], 32'h3010 + 32'(i * 4)});
      step();
    end
    // Reserved source behaves as ALU.
    mSet(32'h3040, 1, 5'd11, 2'd3, 32'h0000_DEAD, 32'h80FF_7F01, 2'd0, 3'd0);
    q.push_back('{1'b1, 5'd11, 32'h0000_DEAD, 32'h3040});
    step();
    // Write to $0 and a no-write instruction both retire without writing.
    mSet(32'h3044, 1, 5'd0, 2'd0, 32'h0000_0042, 32'h0, 2'd0, 3'd0);
    q.push_back('{1'b0, 5'd0, 32'h0000_0042, 32'h3044});
    step();
    mSet(32'h3048, 0, 5'd7, 2'd0, 32'h0000_0077, 32'h0, 2'd0, 3'd0);
    q.push_back('{1'b0, 5'd7, 32'h0000_0077, 32'h3048});
    step();
    idle();
    step();

    // Collision: md wins, M skids, a second md waits behind the skid.
    mdSet(32'h3100, 5'd8, 32'hABCD);
    mSet(32'h3104, 1, 5'd9, 2'd0, 32'h0000_0099, 32'h0, 2'd0, 3'd0);
    #1;
    chk("coll_pre_m_ready", {31'h0, m_ready}, 32'h1);
    chk("coll_pre_md_ready", {31'h0, md_ready}, 32'h1);
    q.push_back('{1'b1, 5'd8, 32'hABCD, 32'h3100});
    q.push_back('{1'b1, 5'd9, 32'h0000_0099, 32'h3104});
    step();
    m_valid = 0;
    mdSet(32'h3108, 5'd10, 32'h0000_0055);
    #1;
    chk("coll_pending9", pending, 32'h0000_0200);
    chk("coll_m_ready", {31'h0, m_ready}, 32'h0);
    chk("coll_md_ready", {31'h0, md_ready}, 32'h0);
    q.push_back('{1'b1, 5'd10, 32'h0000_0055, 32'h3108});
    step();
    chk("coll_pending_clear", pending, 32'h0);
    chk("coll_md_ready_after", {31'h0, md_ready}, 32'h1);
    step();
    idle();
    step();

    // Skidded write to $0 never shows up in pending.
    mdSet(32'h3200, 5'd3, 32'h0000_0033);
    mSet(32'h3204, 1, 5'd0, 2'd0, 32'h0000_0077, 32'h0, 2'd0, 3'd0);
    q.push_back('{1'b1, 5'd3, 32'h0000_0033, 32'h3200});
    q.push_back('{1'b0, 5'd0, 32'h0000_0077, 32'h3204});
    step();
    idle();
    #1;
    chk("zero_skid_pending", pending, 32'h0);
    chk("zero_skid_m_ready", {31'h0, m_ready}, 32'h0);
    step();
    step();

    // Reset while the skid is full: the skidded entry must vanish.
    mdSet(32'h3300, 5'd12, 32'h0000_000C);
    mSet(32'h3304, 1, 5'd13, 2'd0, 32'h0000_000D, 32'h0, 2'd0, 3'd0);
    q.push_back('{1'b1, 5'd12, 32'h0000_000C, 32'h3300});
    step();
    idle();
    #1;
    chk("rst_pre_pending13", pending, 32'h0000_2000);
    reset = 1;
    step();
    resetChecks("midreset");
    reset = 0;
    step(); step(); step();

    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
